// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: in-order source A has priority; long-latency source B is queued and drained with a starvation guard.
// Optional `REGWB_PENDING_EN adds pending_mask, a per-register flag for every destination still waiting in the B queue.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4:0]               a_rd,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_rd,
  input  logic [31:0]              b_data,
  output logic                     wr_en,
  output logic [4:0]               wr_addr,
  output logic [31:0]              wr_data,
  output logic [$clog2(DEPTH):0]   b_count,
`ifdef REGWB_PENDING_EN
  output logic [31:0]              pending_mask,
`endif
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  // Down-counter of denials left before the B head is forced through.
  logic [SW-1:0] starve_left;

  logic        head_v;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic        starve_hit;
  logic        same_reg;
  logic        grant_a;
  logic        grant_b;
  logic        push;

  assign head_v     = (b_count != '0);
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign starve_hit = (starve_left == '0);
  // The B head is older than the A request, so it must land first on a shared register.
  assign same_reg   = (a_rd == head_rd) && (a_rd != 5'd0);
  assign grant_b    = head_v && (!a_valid || starve_hit || same_reg);
  assign grant_a    = a_valid && !grant_b;
  assign a_ready    = !grant_b;
  assign b_ready    = (b_count < CW'(DEPTH));
  assign push       = b_valid && b_ready;
  assign busy       = head_v;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= b_rd;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      b_count     <= '0;
      starve_left <= SW'(STARVE_LIMIT);
    end else begin
      if (grant_b) begin
        wr_en   <= (head_rd != 5'd0);
        wr_addr <= head_rd;
        wr_data <= head_data;
      end else if (grant_a) begin
        wr_en   <= (a_rd != 5'd0);
        wr_addr <= a_rd;
        wr_data <= a_data;
      end else begin
        wr_en   <= 1'b0;
      end

      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (grant_b) rd_ptr <= rd_ptr + 1'b1;

      case ({push, grant_b})
        2'b10:   b_count <= b_count + 1'b1;
        2'b01:   b_count <= b_count - 1'b1;
        default: b_count <= b_count;
      endcase

      if (!head_v || grant_b)
        starve_left <= SW'(STARVE_LIMIT);
      else if (!starve_hit)
        starve_left <= starve_left - 1'b1;
    end
  end

`ifdef REGWB_PENDING_EN
  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - rd_ptr} < b_count) && (fifo_rd[i] != 5'd0))
        pending_mask[fifo_rd[i]] = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued as grants are driven and checked on the following cycle.
// Build with +define+REGWB_PENDING_EN to also cover pending_mask.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  b_count;
  logic        busy;
`ifdef REGWB_PENDING_EN
  logic [31:0] pending_mask;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .b_count(b_count),
`ifdef REGWB_PENDING_EN
    .pending_mask(pending_mask),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // One clock: any write predicted for this edge must appear now, otherwise the port must stay idle.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("wr_en", {31'd0, wr_en}, 32'd1);
      chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
      chk("wr_data", wr_data, e.data);
    end else begin
      chk("wr_en_idle", {31'd0, wr_en}, 32'd0);
    end
  endtask

  task automatic drive_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
    a_valid = v;
    a_rd    = rd;
    a_data  = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
    b_valid = v;
    b_rd    = rd;
    b_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_a(1'b1, 5'd4, 32'h44);
    drive_b(1'b1, 5'd6, 32'h66);

    // Reset held two cycles with both sources requesting.
    tick();
    chk("rst_count", {29'd0, b_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rst_count2", {29'd0, b_count}, 32'd0);
    chk("rst_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_data", wr_data, 32'd0);

    rst_n = 1'b1;
    drive_b(1'b0, 5'd0, 32'd0);
    #1;
    chk("first_a_ready", {31'd0, a_ready}, 32'd1);
    expect_wr(5'd4, 32'h44);
    tick();

    // A only.
    drive_a(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("aonly_ready", {31'd0, a_ready}, 32'd1);
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    drive_a(1'b0, 5'd0, 32'd0);
    tick();
    chk("hold_addr", {27'd0, wr_addr}, 32'd5);
    chk("hold_data", wr_data, 32'hDEADBEEF);

    // Fill B while A keeps winning, then starvation forces the head through.
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 5'(10 + i), 32'hA0 + i);
      drive_b(1'b1, 5'(1 + i), 32'hB1 + i);
      #1;
      chk("fill_a_ready", {31'd0, a_ready}, 32'd1);
      chk("fill_b_ready", {31'd0, b_ready}, 32'd1);
      expect_wr(5'(10 + i), 32'hA0 + i);
      tick();
      chk("fill_count", {29'd0, b_count}, 32'(i + 1));
    end
    drive_b(1'b0, 5'd0, 32'd0);
    drive_a(1'b1, 5'd14, 32'hA4);
    #1;
    chk("full_b_ready", {31'd0, b_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("starve_a_ready", {31'd0, a_ready}, 32'd0);
    expect_wr(5'd1, 32'hB1);
    tick();
    chk("starve_count", {29'd0, b_count}, 32'd3);
    #1;
    chk("restart_a_ready", {31'd0, a_ready}, 32'd1);
    expect_wr(5'd14, 32'hA4);
    tick();
    drive_a(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_a_ready", {31'd0, a_ready}, 32'd0);
      expect_wr(5'(2 + i), 32'hB2 + i);
      tick();
    end
    chk("drain_count", {29'd0, b_count}, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd0);

    // Same-register conflict: older B value lands first.
    drive_b(1'b1, 5'd7, 32'h1);
    tick();
    drive_b(1'b0, 5'd0, 32'd0);
    drive_a(1'b1, 5'd7, 32'h2);
    #1;
    chk("conflict_a_ready", {31'd0, a_ready}, 32'd0);
    expect_wr(5'd7, 32'h1);
    tick();
    #1;
    chk("conflict_a_ready2", {31'd0, a_ready}, 32'd1);
    expect_wr(5'd7, 32'h2);
    tick();
    drive_a(1'b0, 5'd0, 32'd0);

    // Register 0 requests are consumed without a write.
    drive_b(1'b1, 5'd0, 32'h55);
    tick();
    chk("r0_count1", {29'd0, b_count}, 32'd1);
    drive_b(1'b0, 5'd0, 32'd0);
    drive_a(1'b1, 5'd0, 32'h66);
    #1;
    chk("r0_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    drive_a(1'b0, 5'd0, 32'd0);
    chk("r0_count_hold", {29'd0, b_count}, 32'd1);
    tick();
    chk("r0_count_pop", {29'd0, b_count}, 32'd0);

    // Two queued entries behind an A stream; pending flags track them.
    drive_a(1'b1, 5'd20, 32'hC0);
    drive_b(1'b1, 5'd3, 32'h33);
    expect_wr(5'd20, 32'hC0);
    tick();
    drive_a(1'b1, 5'd21, 32'hC1);
    drive_b(1'b1, 5'd9, 32'h99);
    expect_wr(5'd21, 32'hC1);
    tick();
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
    #1;
    chk("pend_count", {29'd0, b_count}, 32'd2);
`ifdef REGWB_PENDING_EN
    chk("pending_mask", pending_mask, 32'h00000208);
`endif
    expect_wr(5'd3, 32'h33);
    tick();
    expect_wr(5'd9, 32'h99);
    tick();
    chk("pend_drained", {29'd0, b_count}, 32'd0);
`ifdef REGWB_PENDING_EN
    chk("pending_clear", pending_mask, 32'd0);
`endif
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
